// File: rtl/multicore_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types for the multicore memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int DEFAULT_WORD_W = 32;

    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DWRITE = 3'd1,
        SNOOP  = 3'd2,
        DFWD   = 3'd3,
        DREAD  = 3'd4,
        IFETCH = 3'd5
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/multicore_mem_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Picks the first requester at or after ptr, modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [IW-1:0] idx;

    // Scan from the far end back toward ptr so the final hit is the nearest requester.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int j = N - 1; j >= 0; j--) begin
            idx = IW'((int'(ptr) + j) % N);
            if (req[idx]) begin
                gnt_idx = idx;
                any     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicore_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : multicore_mem_arbiter
// Description : Round-robin RAM arbiter with snoop forwarding and LL/SC tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module multicore_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int CPUS   = 4,
    parameter int WORD_W = DEFAULT_WORD_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS*WORD_W-1:0]   iaddr,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*WORD_W-1:0]   daddr,
    input  logic [CPUS*WORD_W-1:0]   dstore,
    input  logic [CPUS-1:0]          cctrans,
    input  logic [CPUS-1:0]          ccwrite,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*WORD_W-1:0]   iload,
    output logic [CPUS*WORD_W-1:0]   dload,
    output logic [CPUS-1:0]          ccwait,
    output logic [CPUS-1:0]          ccinv,
    output logic [WORD_W-1:0]        ccsnoopaddr,
    input  logic [CPUS-1:0]          llsc_set,
    output logic [CPUS-1:0]          llsc_valid,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [WORD_W-1:0]        ramaddr,
    output logic [WORD_W-1:0]        ramstore,
    input  logic [WORD_W-1:0]        ramload,
    input  logic [1:0]               ramstate
);

    localparam int IW = $clog2(CPUS);

    arb_state_t        state, next_state;
    logic [IW-1:0]     sel, next_sel, owner, next_owner;
    logic [IW-1:0]     dptr, next_dptr, iptr, next_iptr;
    logic [WORD_W-1:0] iaddr_a  [CPUS];
    logic [WORD_W-1:0] daddr_a  [CPUS];
    logic [WORD_W-1:0] dstore_a [CPUS];
    logic [WORD_W-1:0] iload_a  [CPUS];
    logic [WORD_W-1:0] dload_a  [CPUS];
    logic [WORD_W-1:0] res_addr [CPUS];
    logic [CPUS-1:0]   res_valid;
    logic              wr_any, rd_any, fe_any;
    logic [IW-1:0]     wr_idx, rd_idx, fe_idx;
    logic              snoop_hit;
    logic [IW-1:0]     snoop_owner;
    logic              wr_done;
    logic [IW-1:0]     wr_core;
    logic [WORD_W-1:0] wr_addr;
    logic              ram_access;

    generate
        for (genvar k = 0; k < CPUS; k++) begin : g_lane
            assign iaddr_a[k]  = iaddr[k*WORD_W +: WORD_W];
            assign daddr_a[k]  = daddr[k*WORD_W +: WORD_W];
            assign dstore_a[k] = dstore[k*WORD_W +: WORD_W];
            assign iload[k*WORD_W +: WORD_W] = iload_a[k];
            assign dload[k*WORD_W +: WORD_W] = dload_a[k];
        end
    endgenerate

    rr_arbiter #(.N(CPUS), .IW(IW)) u_wr_arb (.req(dWEN), .ptr(dptr), .gnt_idx(wr_idx), .any(wr_any));
    rr_arbiter #(.N(CPUS), .IW(IW)) u_rd_arb (.req(dREN), .ptr(dptr), .gnt_idx(rd_idx), .any(rd_any));
    rr_arbiter #(.N(CPUS), .IW(IW)) u_fe_arb (.req(iREN), .ptr(iptr), .gnt_idx(fe_idx), .any(fe_any));

    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] idx);
        return (int'(idx) == CPUS - 1) ? '0 : idx + IW'(1);
    endfunction

    assign ram_access = (ramstate == RAM_ACCESS);

    // Lowest-numbered other core holding the line Modified becomes the forwarder.
    always_comb begin
        snoop_hit   = 1'b0;
        snoop_owner = '0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            if (ccwrite[k] && (IW'(k) != sel)) begin
                snoop_hit   = 1'b1;
                snoop_owner = IW'(k);
            end
        end
    end

    always_comb begin
        next_state  = state;
        next_sel    = sel;
        next_owner  = owner;
        next_dptr   = dptr;
        next_iptr   = iptr;
        iwait       = '1;
        dwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        wr_done     = 1'b0;
        wr_core     = sel;
        wr_addr     = '0;
        for (int k = 0; k < CPUS; k++) begin
            iload_a[k] = '0;
            dload_a[k] = '0;
        end
        unique case (state)
            IDLE: begin
                if (wr_any) begin
                    next_state = DWRITE;
                    next_sel   = wr_idx;
                end else if (rd_any) begin
                    next_state = SNOOP;
                    next_sel   = rd_idx;
                end else if (fe_any) begin
                    next_state = IFETCH;
                    next_sel   = fe_idx;
                end
            end
            DWRITE: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr_a[sel];
                ramstore = dstore_a[sel];
                if (ram_access) begin
                    dwait[sel] = 1'b0;
                    next_state = IDLE;
                    next_dptr  = rr_next(sel);
                    wr_done    = 1'b1;
                    wr_core    = sel;
                    wr_addr    = daddr_a[sel];
                end
            end
            SNOOP: begin
                ccsnoopaddr = daddr_a[sel];
                for (int k = 0; k < CPUS; k++) begin
                    if (IW'(k) != sel) begin
                        ccwait[k] = 1'b1;
                        ccinv[k]  = cctrans[sel];
                    end
                end
                next_owner = snoop_owner;
                next_state = snoop_hit ? DFWD : DREAD;
            end
            DFWD: begin
                for (int k = 0; k < CPUS; k++) begin
                    if (IW'(k) != sel) ccwait[k] = 1'b1;
                end
                dload_a[sel] = dstore_a[owner];
                ramWEN       = 1'b1;
                ramaddr      = daddr_a[owner];
                ramstore     = dstore_a[owner];
                if (ram_access) begin
                    dwait[sel]   = 1'b0;
                    dwait[owner] = 1'b0;
                    next_state   = IDLE;
                    wr_done      = 1'b1;
                    wr_core      = owner;
                    wr_addr      = daddr_a[owner];
                end
            end
            DREAD: begin
                ramREN       = 1'b1;
                ramaddr      = daddr_a[sel];
                dload_a[sel] = ramload;
                if (ram_access) begin
                    dwait[sel] = 1'b0;
                    next_state = IDLE;
                    next_dptr  = rr_next(sel);
                end
            end
            IFETCH: begin
                ramREN       = 1'b1;
                ramaddr      = iaddr_a[sel];
                iload_a[sel] = ramload;
                if (ram_access) begin
                    iwait[sel] = 1'b0;
                    next_state = IDLE;
                    next_iptr  = rr_next(sel);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            sel   <= '0;
            owner <= '0;
            dptr  <= '0;
            iptr  <= '0;
        end else begin
            state <= next_state;
            sel   <= next_sel;
            owner <= next_owner;
            dptr  <= next_dptr;
            iptr  <= next_iptr;
        end
    end

    // A fresh LL outranks a same-cycle kill; the writer keeps its own reservation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            res_valid <= '0;
            for (int k = 0; k < CPUS; k++) res_addr[k] <= '0;
        end else begin
            for (int k = 0; k < CPUS; k++) begin
                if (llsc_set[k]) begin
                    res_valid[k] <= 1'b1;
                    res_addr[k]  <= daddr_a[k];
                end else if ((wr_done && (IW'(k) != wr_core) && (res_addr[k] == wr_addr)) ||
                             (ccinv[k] && (res_addr[k] == ccsnoopaddr))) begin
                    res_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign llsc_valid = res_valid;

endmodule
`default_nettype wire

// File: tb/tb_multicore_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_multicore_mem_arbiter
// Description : Random and directed bench for multicore_mem_arbiter with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicore_mem_arbiter;

    localparam int CPUS = 4;
    localparam int W    = 32;
    localparam int K_NONE = 0, K_WR = 1, K_SNP = 2, K_FWD = 3, K_RD = 4, K_IF = 5;

    logic              CLK = 1'b0;
    logic              RST;
    logic [CPUS-1:0]   iREN, dREN, dWEN, cctrans, ccwrite, llsc_set;
    logic [CPUS*W-1:0] iaddr, daddr, dstore;
    logic [CPUS-1:0]   iwait, dwait, ccwait, ccinv, llsc_valid;
    logic [CPUS*W-1:0] iload, dload;
    logic [W-1:0]      ccsnoopaddr, ramaddr, ramstore, ramload;
    logic              ramREN, ramWEN;
    logic [1:0]        ramstate;

    int checks   = 0;
    int failures = 0;

    multicore_mem_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .cctrans(cctrans), .ccwrite(ccwrite),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .ccwait(ccwait),
        .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .llsc_set(llsc_set), .llsc_valid(llsc_valid),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    // ---------------- RAM environment ----------------
    logic [W-1:0] mem [0:1023];
    int   lat = 1;
    int   cnt = 0;
    logic err_now = 1'b0;

    always_comb begin
        if (!(ramREN || ramWEN))  ramstate = 2'd0;
        else if (err_now)         ramstate = 2'd3;
        else if (cnt >= lat - 1)  ramstate = 2'd2;
        else                      ramstate = 2'd1;
    end
    assign ramload = mem[ramaddr[9:0]];

    always @(posedge CLK) begin
        if (ramstate == 2'd2) begin
            cnt <= 0;
            if (ramWEN) mem[ramaddr[9:0]] <= ramstore;
        end else if (ramREN || ramWEN) begin
            if (!err_now) cnt <= cnt + 1;
        end else begin
            cnt <= 0;
        end
    end

    function automatic logic [W-1:0] lane(input logic [CPUS*W-1:0] v, input int k);
        return v[k*W +: W];
    endfunction

    function automatic logic [W-1:0] memat(input logic [W-1:0] a);
        return mem[a[9:0]];
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int              m_kind, m_sel, m_owner, m_dptr, m_iptr;
    logic [W-1:0]    m_res_addr [CPUS];
    logic [CPUS-1:0] m_res_val, n_val;
    bit              model_ok = 1'b0;
    logic            acc;
    logic [CPUS-1:0] e_iwait, e_dwait, e_ccwait, e_ccinv;
    logic [CPUS*W-1:0] e_iload, e_dload;
    logic            e_ren, e_wen;
    logic [W-1:0]    e_addr, e_store, e_snp, wa;

    function automatic int pick(input logic [CPUS-1:0] req, input int ptr);
        for (int j = 0; j < CPUS; j++)
            if (req[(ptr + j) % CPUS]) return (ptr + j) % CPUS;
        return -1;
    endfunction

    always @(negedge CLK) begin
        acc = (ramstate == 2'd2);
        if (model_ok) begin
            e_iwait = '1; e_dwait = '1; e_ccwait = '0; e_ccinv = '0;
            e_iload = '0; e_dload = '0; e_ren = 1'b0; e_wen = 1'b0;
            e_addr = '0; e_store = '0; e_snp = '0;
            case (m_kind)
                K_WR: begin
                    e_wen = 1'b1; e_addr = lane(daddr, m_sel); e_store = lane(dstore, m_sel);
                    if (acc) e_dwait[m_sel] = 1'b0;
                end
                K_SNP: begin
                    e_snp = lane(daddr, m_sel);
                    for (int k = 0; k < CPUS; k++)
                        if (k != m_sel) begin e_ccwait[k] = 1'b1; e_ccinv[k] = cctrans[m_sel]; end
                end
                K_FWD: begin
                    for (int k = 0; k < CPUS; k++) if (k != m_sel) e_ccwait[k] = 1'b1;
                    e_dload[m_sel*W +: W] = lane(dstore, m_owner);
                    e_wen = 1'b1; e_addr = lane(daddr, m_owner); e_store = lane(dstore, m_owner);
                    if (acc) begin e_dwait[m_sel] = 1'b0; e_dwait[m_owner] = 1'b0; end
                end
                K_RD: begin
                    e_ren = 1'b1; e_addr = lane(daddr, m_sel);
                    e_dload[m_sel*W +: W] = memat(e_addr);
                    if (acc) e_dwait[m_sel] = 1'b0;
                end
                K_IF: begin
                    e_ren = 1'b1; e_addr = lane(iaddr, m_sel);
                    e_iload[m_sel*W +: W] = memat(e_addr);
                    if (acc) e_iwait[m_sel] = 1'b0;
                end
                default: ;
            endcase
            chk("iwait", iwait, e_iwait);
            chk("dwait", dwait, e_dwait);
            chk("iload", iload, e_iload);
            chk("dload", dload, e_dload);
            chk("ccwait", ccwait, e_ccwait);
            chk("ccinv", ccinv, e_ccinv);
            chk("ramREN", ramREN, e_ren);
            chk("ramWEN", ramWEN, e_wen);
            chk("llsc_valid", llsc_valid, m_res_val);
            if (m_kind != K_SNP) chk("ramaddr", ramaddr, e_addr);
            if (m_kind == K_NONE || e_wen) chk("ramstore", ramstore, e_store);
            if (m_kind == K_NONE || m_kind == K_SNP) chk("ccsnoopaddr", ccsnoopaddr, e_snp);
        end

        if (RST) begin
            m_kind = K_NONE; m_sel = 0; m_owner = 0; m_dptr = 0; m_iptr = 0;
            m_res_val = '0;
            for (int k = 0; k < CPUS; k++) m_res_addr[k] = '0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            n_val = m_res_val;
            if ((m_kind == K_WR || m_kind == K_FWD) && acc) begin
                int w;
                w  = (m_kind == K_WR) ? m_sel : m_owner;
                wa = lane(daddr, w);
                for (int j = 0; j < CPUS; j++)
                    if (j != w && m_res_addr[j] == wa) n_val[j] = 1'b0;
            end
            if (m_kind == K_SNP && cctrans[m_sel])
                for (int j = 0; j < CPUS; j++)
                    if (j != m_sel && m_res_addr[j] == lane(daddr, m_sel)) n_val[j] = 1'b0;
            for (int k = 0; k < CPUS; k++)
                if (llsc_set[k]) begin n_val[k] = 1'b1; m_res_addr[k] = lane(daddr, k); end
            m_res_val = n_val;

            case (m_kind)
                K_NONE: begin
                    if (pick(dWEN, m_dptr) >= 0)      begin m_kind = K_WR;  m_sel = pick(dWEN, m_dptr); end
                    else if (pick(dREN, m_dptr) >= 0) begin m_kind = K_SNP; m_sel = pick(dREN, m_dptr); end
                    else if (pick(iREN, m_iptr) >= 0) begin m_kind = K_IF;  m_sel = pick(iREN, m_iptr); end
                end
                K_WR:  if (acc) begin m_dptr = (m_sel + 1) % CPUS; m_kind = K_NONE; end
                K_SNP: begin
                    m_owner = -1;
                    for (int k = 0; k < CPUS; k++)
                        if (k != m_sel && ccwrite[k] && m_owner < 0) m_owner = k;
                    m_kind = (m_owner >= 0) ? K_FWD : K_RD;
                end
                K_FWD: if (acc) m_kind = K_NONE;
                K_RD:  if (acc) begin m_dptr = (m_sel + 1) % CPUS; m_kind = K_NONE; end
                K_IF:  if (acc) begin m_iptr = (m_sel + 1) % CPUS; m_kind = K_NONE; end
                default: m_kind = K_NONE;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; llsc_set = '0;
        iaddr = '0; daddr = '0; dstore = '0; err_now = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic idle_gap();
        step();
        clear_inputs();
        step();
        step();
    endtask

    function automatic logic [W-1:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return 32'h40;
            1:       return 32'h80;
            2:       return 32'h100;
            3:       return 32'h140;
            default: return 32'($urandom_range(0, 255)) << 2;
        endcase
    endfunction

    int order[$];
    int exp_order[5];
    int n;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 ^ 32'(i * 65537);
        mem[10'h080] = 32'h1234_5678;
        exp_order = '{0, 1, 2, 3, 0};

        clear_inputs();
        RST = 1'b1; iREN = '1; dREN = '1; dWEN = '1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_iwait", iwait, 4'hF);
        chk("reset_dwait", dwait, 4'hF);
        chk("reset_ramREN", ramREN, 1'b0);
        chk("reset_ramWEN", ramWEN, 1'b0);
        step();
        RST = 1'b0;
        clear_inputs();
        step();

        // Four fetchers, zero-wait RAM: strict rotation.
        iREN = 4'hF;
        for (int k = 0; k < CPUS; k++) iaddr[k*W +: W] = 32'h10 + 32'(4 * k);
        for (int c = 0; c < 16 && order.size() < 5; c++) begin
            @(negedge CLK);
            for (int k = 0; k < CPUS; k++)
                if (!iwait[k]) begin
                    order.push_back(k);
                    chk("ifetch_data", iload[k*W +: W], memat(lane(iaddr, k)));
                end
        end
        chk("grant_count", order.size(), 5);
        for (int i = 0; i < 5 && i < order.size(); i++) chk("grant_order", order[i], exp_order[i]);

        // Write beats fetch.
        idle_gap();
        dWEN[2] = 1'b1; daddr[2*W +: W] = 32'h200; dstore[2*W +: W] = 32'hCAFE_0002;
        iREN[0] = 1'b1; iaddr[0 +: W] = 32'h44;
        @(negedge CLK); @(negedge CLK);
        chk("wr_first_dwait", dwait, 4'b1011);
        chk("wr_first_ramWEN", ramWEN, 1'b1);
        step();
        dWEN = '0;
        @(negedge CLK); @(negedge CLK);
        chk("fetch_after_iwait", iwait, 4'b1110);

        // Snoop hit: core 3 forwards Modified data to core 1.
        idle_gap();
        dREN[1] = 1'b1; cctrans[1] = 1'b1; daddr[1*W +: W] = 32'h100;
        ccwrite[3] = 1'b1; dstore[3*W +: W] = 32'hDEAD_BEEF; daddr[3*W +: W] = 32'h100;
        @(negedge CLK); @(negedge CLK);
        chk("fwd_ccinv", ccinv, 4'b1101);
        chk("fwd_ccwait", ccwait, 4'b1101);
        @(negedge CLK);
        chk("fwd_dwait", dwait, 4'b0101);
        chk("fwd_dload", dload[1*W +: W], 32'hDEAD_BEEF);
        step();
        chk("fwd_ram", mem[10'h100], 32'hDEAD_BEEF);

        // Read miss with 3-cycle RAM.
        idle_gap();
        lat = 3;
        dREN[0] = 1'b1; daddr[0 +: W] = 32'h80;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            n++;
            if (!dwait[0]) break;
        end
        chk("read_latency", n, 5);
        chk("read_dload", dload[0 +: W], 32'h1234_5678);
        idle_gap();
        lat = 1;

        // LL/SC: write by core 0 kills core 2's reservation only.
        llsc_set = 4'b0101; daddr[0 +: W] = 32'h40; daddr[2*W +: W] = 32'h40;
        step();
        llsc_set = '0; dWEN[0] = 1'b1; dstore[0 +: W] = 32'h5C;
        @(negedge CLK);
        chk("llsc_before", llsc_valid, 4'b0101);
        step();
        step();
        dWEN = '0;
        @(negedge CLK);
        chk("llsc_after", llsc_valid, 4'b0001);

        // Randomised traffic against the model.
        idle_gap();
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c % 100 == 0) lat = $urandom_range(1, 3);
            RST      = ($urandom_range(0, 249) == 0);
            err_now  = ($urandom_range(0, 9) == 0);
            iREN     = CPUS'($urandom & $urandom);
            dREN     = CPUS'($urandom & $urandom);
            dWEN     = CPUS'($urandom & $urandom & $urandom);
            cctrans  = CPUS'($urandom);
            ccwrite  = CPUS'($urandom & $urandom & $urandom);
            llsc_set = CPUS'($urandom & $urandom & $urandom);
            for (int k = 0; k < CPUS; k++) begin
                iaddr[k*W +: W]  = 32'($urandom_range(0, 255)) << 2;
                daddr[k*W +: W]  = rand_addr();
                dstore[k*W +: W] = $urandom;
            end
        end
        step();
        RST = 1'b0;
        idle_gap();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
